// File: rtl/ql_pkg.sv
// Shared definitions for the QL video fetch path.
// FSM encoding and default SDRAM placement of video RAM.
package ql_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } fetch_st_t;

  // ULA word 0 sits at SDRAM byte $20000
  localparam logic [22:0] VRAM_BASE_WORD = 23'h010000;

endpackage

// File: rtl/ql_vram_entry.sv
// One video buffer entry: valid/tag/data with two tag comparators
// (current address and the following word).
module ql_vram_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        wr,
  input  logic [14:0] wr_tag,
  input  logic [15:0] wr_data,
  input  logic [14:0] look_a,
  input  logic [14:0] look_b,
  output logic        hit_a,
  output logic        hit_b,
  output logic [15:0] data
);

  logic        valid;
  logic [14:0] tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  assign hit_a = valid && (tag == look_a);
  assign hit_b = valid && (tag == look_b);

endmodule

// File: rtl/ql_vram_fetch.sv
// ZX8301 video word buffer: two entries over SDRAM, demand fetch
// on a miss and next-word prefetch while the current word hits.
module ql_vram_fetch
  import ql_pkg::*;
#(
  parameter int                MEM_AW    = 23,
  parameter logic [MEM_AW-1:0] BASE_WORD = MEM_AW'(VRAM_BASE_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       addr_in,
  output logic [15:0]       dout,
  input  logic              flush,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [15:0]       mem_data,
  output logic              underrun
);

  fetch_st_t   state, state_nx;
  logic [14:0] tag_q, tag_nx;
  logic        victim_q, victim_nx;
  logic        discard_q, discard_nx;
  logic        start, fill, wr;
  logic [14:0] next_addr;
  logic [14:0] prev_addr;
  logic        primed;
  logic [1:0]  hit_a, hit_b;
  logic [15:0] data0, data1;
  logic        cur_hit, nxt_hit;

  assign next_addr = addr_in + 15'd1;
  assign cur_hit   = |hit_a;
  assign nxt_hit   = |hit_b;

  // A flush in the fill cycle must win over the write
  assign wr = fill && !discard_q && !flush;

  ql_vram_entry u_e0 (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .wr      (wr && !victim_q),
    .wr_tag  (tag_q),
    .wr_data (mem_data),
    .look_a  (addr_in),
    .look_b  (next_addr),
    .hit_a   (hit_a[0]),
    .hit_b   (hit_b[0]),
    .data    (data0)
  );

  ql_vram_entry u_e1 (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .wr      (wr && victim_q),
    .wr_tag  (tag_q),
    .wr_data (mem_data),
    .look_a  (addr_in),
    .look_b  (next_addr),
    .hit_a   (hit_a[1]),
    .hit_b   (hit_b[1]),
    .data    (data1)
  );

  always_comb begin
    state_nx   = state;
    tag_nx     = tag_q;
    victim_nx  = victim_q;
    discard_nx = discard_q;
    start      = 1'b0;
    fill       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!cur_hit) begin
          start  = 1'b1;
          tag_nx = addr_in;
        end else if (!nxt_hit) begin
          start  = 1'b1;
          tag_nx = next_addr;
        end
        if (start) begin
          // replace whichever entry is not serving addr_in
          victim_nx  = hit_a[0];
          discard_nx = 1'b0;
          state_nx   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (mem_valid) begin
            fill     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_valid) begin
          fill     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (flush && state != ST_IDLE) discard_nx = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tag_q     <= '0;
      victim_q  <= 1'b0;
      discard_q <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state     <= state_nx;
      tag_q     <= tag_nx;
      victim_q  <= victim_nx;
      discard_q <= discard_nx;
      if (start) mem_addr <= BASE_WORD + MEM_AW'(tag_nx);
    end
  end

  assign mem_req = (state == ST_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout      <= '0;
      underrun  <= 1'b0;
      prev_addr <= '0;
      primed    <= 1'b0;
    end else begin
      if (hit_a[0])      dout <= data0;
      else if (hit_a[1]) dout <= data1;
      underrun  <= primed && (addr_in != prev_addr) && !cur_hit;
      prev_addr <= addr_in;
      primed    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ql_vram_fetch.sv
// Self-checking bench for ql_vram_fetch: SDRAM model plus
// directed scenarios and randomized address walks.
module tb_ql_vram_fetch;

  localparam logic [22:0] BASE = 23'h010000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] addr_in = '0;
  logic [15:0] dout;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        underrun;

  int n_cmp = 0;
  int n_err = 0;

  bit rand_mode = 1'b0;
  int lat_fix = 2;
  bit poison = 1'b0;

  logic [22:0] issued[$];
  int          upulses = 0;
  logic [14:0] a_q = '0;

  ql_vram_fetch dut (
    .clk       (clk),
    .reset     (rst),
    .addr_in   (addr_in),
    .dout      (dout),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [14:0] t);
    return {1'b0, t} ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always_ff @(posedge clk) a_q <= addr_in;

  // SDRAM model: ack after 0..2 clk, data 0..3 clk after ack
  initial begin
    int          ph = 0;
    int          cnt = 0;
    int          lcnt = 0;
    bit          ack_now;
    logic [22:0] d;
    logic [15:0] m_data = '0;
    forever begin
      @(posedge clk);
      mem_ack   <= 1'b0;
      mem_valid <= 1'b0;
      ack_now = 1'b0;
      if (ph == 0 && mem_req) begin
        cnt = rand_mode ? int'($urandom_range(0, 2)) : 0;
        ph  = 1;
      end
      if (ph == 1) begin
        if (cnt == 0) ack_now = 1'b1;
        else cnt--;
      end
      if (ack_now) begin
        mem_ack <= 1'b1;
        d = mem_addr - BASE;
        m_data = poison ? 16'hDEAD : f(d[14:0]);
        lcnt = rand_mode ? int'($urandom_range(0, 3)) : lat_fix;
        ph = 2;
      end
      if (ph == 2) begin
        if (lcnt == 0) begin
          mem_valid <= 1'b1;
          mem_data  <= m_data;
          ph = 3;
        end else begin
          lcnt--;
        end
      end else if (ph == 3) begin
        ph = 0;
      end
    end
  end

  // Protocol and output monitor
  initial begin
    logic [15:0] last_dout = '0;
    logic        req_prev = 1'b0;
    logic        un_prev = 1'b0;
    logic [22:0] last_addr = '0;
    logic [22:0] d;
    logic [14:0] t;
    forever begin
      @(negedge clk);
      if (!rst && dout !== last_dout)
        check("dout_word", dout, f(a_q));
      if (!rst && mem_req && !req_prev) begin
        issued.push_back(mem_addr);
        d = mem_addr - BASE;
        t = d[14:0];
        check("fetch_tag", (t == a_q) || (t == a_q + 15'd1), 1);
      end
      if (!rst && mem_req && req_prev)
        check("mem_addr_stable", mem_addr, last_addr);
      if (underrun) begin
        upulses++;
        check("underrun_width", un_prev, 0);
      end
      last_dout = dout;
      req_prev  = mem_req;
      un_prev   = underrun;
      last_addr = mem_addr;
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_ack();
    int i = 0;
    while (!mem_ack && i < 30) begin
      tick(1);
      i++;
    end
    check("ack_seen", mem_ack, 1);
  endtask

  task automatic settle_at(input logic [14:0] a);
    addr_in = a;
    tick(50);
  endtask

  initial begin
    logic [14:0] a, b;
    int          i, exp_u;

    // Reset state
    tick(2);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dout", dout, 0);
    check("rst_underrun", underrun, 0);

    // First fill from address 0 with 2-clk data latency
    rand_mode = 1'b0;
    lat_fix   = 2;
    rst = 1'b0;
    i = 0;
    while (dout !== 16'hA5A5 && i < 10) begin
      tick(1);
      i++;
    end
    check("first_dout", dout, 16'hA5A5);
    tick(20);
    check("first_issue_n", issued.size() >= 2, 1);
    if (issued.size() >= 2) begin
      check("first_demand", issued[0], 23'h010000);
      check("first_prefetch", issued[1], 23'h010001);
    end
    check("first_underrun", upulses, 0);

    // Sequential step 0 -> 1
    issued.delete();
    addr_in = 15'd1;
    tick(1);
    check("step_dout", dout, 16'hA5A4);
    tick(20);
    check("step_underrun", upulses, 0);
    check("step_prefetch", issued.size() > 0 ? issued[0] : 23'h0,
          23'h010002);

    // Jump to 0x4000
    issued.delete();
    upulses = 0;
    settle_at(15'h4000);
    check("jump_underrun", upulses, 1);
    check("jump_issue_n", issued.size(), 2);
    if (issued.size() >= 2) begin
      check("jump_demand", issued[0], 23'h014000);
      check("jump_prefetch", issued[1], 23'h014001);
    end
    check("jump_dout", dout, f(15'h4000));

    // Wrap: 7FFE -> 7FFF prefetches tag 0000
    settle_at(15'h7FFE);
    issued.delete();
    upulses = 0;
    settle_at(15'h7FFF);
    check("wrap_underrun", upulses, 0);
    check("wrap_prefetch", issued.size() > 0 ? issued[0] : 23'h0,
          23'h010000);
    check("wrap_dout", dout, f(15'h7FFF));

    // Flush during WAIT discards the returned word
    lat_fix = 3;
    settle_at(15'h1234);
    issued.delete();
    poison = 1'b1;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_ack();
    poison = 1'b0;
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(50);
    check("flush_dout", dout, f(15'h1234));
    check("flush_issue_n", issued.size() >= 3, 1);
    if (issued.size() >= 3) begin
      check("flush_first", issued[0], BASE + 23'h1234);
      check("flush_refetch", issued[1], BASE + 23'h1234);
      check("flush_prefetch", issued[2], BASE + 23'h1235);
    end

    // Reset during WAIT; orphan data must not land
    settle_at(15'h0ABC);
    upulses = 0;
    poison = 1'b1;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_ack();
    poison = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    check("rwait_mem_req", mem_req, 0);
    check("rwait_dout", dout, 0);
    check("rwait_mem_addr", mem_addr, 0);
    tick(1);
    rst = 1'b0;
    tick(50);
    check("rwait_refill", dout, f(15'h0ABC));
    check("rwait_underrun", upulses, 0);

    // Sequential walk, one step per 32 clk, random memory timing
    rand_mode = 1'b1;
    a = 15'($urandom);
    settle_at(a);
    upulses = 0;
    for (int k = 0; k < 40; k++) begin
      a = a + 15'd1;
      addr_in = a;
      tick(32);
      check("seq_dout", dout, f(a));
    end
    check("seq_underrun", upulses, 0);

    // Random jumps with occasional flushes
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 15'd1;
        default: b = 15'($urandom);
      endcase
      exp_u = (b == a || b == a + 15'd1) ? 0 : 1;
      upulses = 0;
      addr_in = b;
      tick(10);
      if ($urandom_range(0, 4) == 0) begin
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
      end
      tick(45);
      check("rand_underrun", upulses, exp_u);
      check("rand_dout", dout, f(b));
      a = b;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
